// File: rtl/lfsr16_1002d.sv
// ---------------------------------------------------------------------------
// Module   : lfsr16_1002d
// Brief    : 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with
//            step enable and synchronous seed load. Optional macro
//            LFSR_ZERO_GUARD_EN steers the all-zero lock-up state to 8'h01.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr16_1002d (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_soft_reset,
  input  logic [7:0] i_seed,
  output logic [7:0] LFSR
);

  localparam logic [7:0] C_RESET_STATE = 8'h01;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       w_fb;
  logic [7:0] w_step;
  logic [7:0] w_seed;

  assign w_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign w_step = {lfsr_q[6:0], w_fb};

`ifdef LFSR_ZERO_GUARD_EN
  assign w_seed = (i_seed == 8'h00) ? C_RESET_STATE : i_seed;
`else
  assign w_seed = i_seed;
`endif

  // Seed load outranks stepping; i_valid is ignored on a load cycle.
  always_comb begin
    lfsr_d = lfsr_q;
    if (i_soft_reset) begin
      lfsr_d = w_seed;
`ifdef LFSR_ZERO_GUARD_EN
    end else if (lfsr_q == 8'h00) begin
      lfsr_d = C_RESET_STATE;
`endif
    end else if (i_valid) begin
      lfsr_d = w_step;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q <= C_RESET_STATE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign LFSR = lfsr_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr16_1002d.sv
// ---------------------------------------------------------------------------
// Module   : tb_lfsr16_1002d
// Brief    : Directed self-checking bench for lfsr16_1002d.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lfsr16_1002d;

  logic       clk;
  logic       i_rst;
  logic       i_valid;
  logic       i_soft_reset;
  logic [7:0] i_seed;
  logic [7:0] LFSR;

  int n_vec;
  int n_err;

  lfsr16_1002d u_dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_soft_reset (i_soft_reset),
    .i_seed       (i_seed),
    .LFSR         (LFSR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic soft_load(input logic [7:0] seed);
    i_seed       = seed;
    i_soft_reset = 1'b1;
    tick();
    i_soft_reset = 1'b0;
  endtask

  task automatic measure_period(input string tag, input logic [7:0] seed);
    int  period;
    bit  found;
    period = 0;
    found  = 1'b0;
    soft_load(seed);
    check({tag, "_seed"}, LFSR, seed);
    i_valid = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (!found && LFSR == seed) begin
        found  = 1'b1;
        period = n;
      end
    end
    i_valid = 1'b0;
    check(tag, period, 255);
  endtask

  initial begin
    logic [7:0] rseed;
    int         early_hits;
    n_vec        = 0;
    n_err        = 0;
    i_rst        = 1'b1;
    i_valid      = 1'b0;
    i_soft_reset = 1'b0;
    i_seed       = 8'h00;

    #1;
    check("reset_state", LFSR, 8'h01);
    tick();
    tick();
    i_rst = 1'b0;
    #3;

    // Step sequence from reset.
    i_valid = 1'b1;
    tick(); check("step1", LFSR, 8'h02);
    tick(); check("step2", LFSR, 8'h04);
    tick(); check("step3", LFSR, 8'h08);
    tick(); check("step4", LFSR, 8'h11);
    i_valid = 1'b0;
    tick(); check("freeze1", LFSR, 8'h11);
    tick(); check("freeze2", LFSR, 8'h11);
    i_valid = 1'b1;
    tick(); check("step5", LFSR, 8'h23);
    tick(); check("step6", LFSR, 8'h47);
    tick(); check("step7", LFSR, 8'h8E);
    tick(); check("step8", LFSR, 8'h1C);

    // Asynchronous hard reset between edges.
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst", LFSR, 8'h01);
    tick(); check("rst_hold", LFSR, 8'h01);
    #2;
    i_rst = 1'b0;
    tick(); check("post_rst_step", LFSR, 8'h02);
    i_valid = 1'b0;

    // Seed load takes priority over step.
    i_valid      = 1'b1;
    i_seed       = 8'hA5;
    i_soft_reset = 1'b1;
    tick(); check("prio_load", LFSR, 8'hA5);
    i_seed = 8'h3C;
    tick(); check("soft_track", LFSR, 8'h3C);
    i_soft_reset = 1'b0;
    i_seed       = 8'hA5;
    i_soft_reset = 1'b1;
    tick();
    i_soft_reset = 1'b0;
    tick(); check("step_a5", LFSR, 8'h4A);
    i_valid = 1'b0;

    measure_period("period_01", 8'h01);
    rseed = 8'($urandom_range(1, 255));
    measure_period("period_rand", rseed);

    // Toggled enable: 255 steps spread over 510 clocks.
    soft_load(8'h01);
    early_hits = 0;
    for (int n = 1; n <= 510; n++) begin
      i_valid = n[0];
      tick();
      if (n <= 508 && LFSR == 8'h01) early_hits++;
    end
    i_valid = 1'b0;
    check("toggle_early", early_hits, 0);
    check("toggle_510", LFSR, 8'h01);

    // Zero seed handling.
    i_valid      = 1'b1;
    i_seed       = 8'h00;
    i_soft_reset = 1'b1;
    tick();
    i_soft_reset = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    check("zero_load", LFSR, 8'h01);
    tick(); check("zero_step", LFSR, 8'h02);
`else
    check("zero_load", LFSR, 8'h00);
    tick(); check("zero_step", LFSR, 8'h00);
    tick(); check("zero_stuck", LFSR, 8'h00);
`endif
    i_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
